// File: rtl/rf_riscv_pkg.sv
// Shared definitions for the multi-port RISC-V integer register file.
//   rf_state_e      : controller state (post-reset clear sweep, then normal operation)
//   RF_XLEN_DEFAULT : default data width
//   RF_ZERO_ADDR    : architectural address of the hard-wired zero register
package rf_riscv_pkg;

  typedef enum logic {
    RF_CLEAR = 1'b0,
    RF_READY = 1'b1
  } rf_state_e;

  localparam int unsigned RF_XLEN_DEFAULT = 32;
  localparam int unsigned RF_ZERO_ADDR    = 0;

endpackage

// File: rtl/rf_riscv_rdport.sv
// One combinational read port of rf_riscv_mp.
// Optional feature macro: RF_RISCV_MP_BYPASS_EN (adds the write-first bypass inputs).
// Ports:
//   i_busy       : clear sweep running; forces the read data to zero
//   i_ra         : read address
//   i_mem        : storage contents, entry 0 unused
//   i_byp_en     : (bypass build) a write is being committed this cycle
//   i_byp_addr   : (bypass build) address of that write
//   i_byp_data   : (bypass build) data of that write
//   o_rd         : read data
module rf_riscv_rdport
  import rf_riscv_pkg::*;
#(
  parameter int unsigned XLEN = RF_XLEN_DEFAULT,
  parameter int unsigned NREG = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                       i_busy,
  input  logic [AW-1:0]              i_ra,
  input  logic [NREG-1:0][XLEN-1:0]  i_mem,
`ifdef RF_RISCV_MP_BYPASS_EN
  input  logic                       i_byp_en,
  input  logic [AW-1:0]              i_byp_addr,
  input  logic [XLEN-1:0]            i_byp_data,
`endif
  output logic [XLEN-1:0]            o_rd
);

  logic w_valid;

  // Masking (x0, out of range, busy) takes priority over the bypass.
  assign w_valid = !i_busy && (i_ra != AW'(RF_ZERO_ADDR)) && (32'(i_ra) < NREG);

  always_comb begin
    o_rd = '0;
    if (w_valid) begin
`ifdef RF_RISCV_MP_BYPASS_EN
      if (i_byp_en && (i_byp_addr == i_ra)) begin
        o_rd = i_byp_data;
      end else begin
        o_rd = i_mem[i_ra];
      end
`else
      o_rd = i_mem[i_ra];
`endif
    end
  end

endmodule

// File: rtl/rf_riscv_mp.sv
// Parametrised multi-port integer register file with x0 hard-wired to zero and a
// sequential post-reset clear sweep.
// Optional feature macro: RF_RISCV_MP_BYPASS_EN (write-first bypass on every read port).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset, restarts the clear sweep
//   WE   : write enable (ignored while busy)
//   A3   : write address
//   WD3  : write data
//   RA   : packed read addresses, port i at RA[i*AW +: AW]
//   RD   : packed read data, port i at RD[i*XLEN +: XLEN]
//   busy : clear sweep in progress
module rf_riscv_mp
  import rf_riscv_pkg::*;
#(
  parameter  int unsigned XLEN = RF_XLEN_DEFAULT,
  parameter  int unsigned NREG = 32,
  parameter  int unsigned NRD  = 2,
  localparam int unsigned AW   = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                WE,
  input  logic [AW-1:0]       A3,
  input  logic [XLEN-1:0]     WD3,
  input  logic [NRD*AW-1:0]   RA,
  output logic [NRD*XLEN-1:0] RD,
  output logic                busy
);

  rf_state_e                r_state, w_state_d;
  logic [AW-1:0]            r_cnt, w_cnt_d;
  logic                     w_clr_en;
  logic                     w_wr_ok;
  // Entry 0 is never written; the read ports mask address 0 to zero.
  logic [NREG-1:0][XLEN-1:0] r_mem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RF_CLEAR;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_clr_en  = 1'b0;
    unique case (r_state)
      RF_CLEAR: begin
        w_clr_en = 1'b1;
        if (r_cnt == AW'(NREG - 1)) begin
          w_state_d = RF_READY;
        end else begin
          w_cnt_d = r_cnt + AW'(1);
        end
      end
      RF_READY: begin
      end
    endcase
  end

  assign busy    = (r_state == RF_CLEAR);
  assign w_wr_ok = (r_state == RF_READY) && WE && (A3 != AW'(RF_ZERO_ADDR)) &&
                   (32'(A3) < NREG);

  // Reset drops any write or clear step sampled on the same edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_clr_en) begin
        r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
        r_mem[A3] <= WD3;
      end
    end
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    rf_riscv_rdport #(
      .XLEN (XLEN),
      .NREG (NREG),
      .AW   (AW)
    ) u_rdport (
      .i_busy     (busy),
      .i_ra       (RA[gi*AW +: AW]),
      .i_mem      (r_mem),
`ifdef RF_RISCV_MP_BYPASS_EN
      .i_byp_en   (w_wr_ok),
      .i_byp_addr (A3),
      .i_byp_data (WD3),
`endif
      .o_rd       (RD[gi*XLEN +: XLEN])
    );
  end

endmodule

// File: tb/tb_rf_riscv_mp.sv
// Self-checking bench for rf_riscv_mp.
// Instance A: XLEN=64, NREG=32, NRD=4. Instance B: XLEN=32, NREG=24, NRD=2.
// Expected values come from an array model updated once per rising edge.
module tb_rf_riscv_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         we_a;
  logic [4:0]   a3_a;
  logic [63:0]  wd_a;
  logic [19:0]  ra_a;
  logic [255:0] rd_a;
  logic         busy_a;
  logic         we_b;
  logic [4:0]   a3_b;
  logic [31:0]  wd_b;
  logic [9:0]   ra_b;
  logic [63:0]  rd_b;
  logic         busy_b;

  rf_riscv_mp #(.XLEN(64), .NREG(32), .NRD(4)) u_dut_a (
    .clk (clk), .rst (rst), .WE (we_a), .A3 (a3_a), .WD3 (wd_a),
    .RA (ra_a), .RD (rd_a), .busy (busy_a)
  );

  rf_riscv_mp #(.XLEN(32), .NREG(24), .NRD(2)) u_dut_b (
    .clk (clk), .rst (rst), .WE (we_b), .A3 (a3_b), .WD3 (wd_b),
    .RA (ra_b), .RD (rd_b), .busy (busy_b)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: index 0 = instance A, 1 = instance B.
  logic [63:0] m_mem [2][32];
  bit          m_busy [2];
  int          m_cleared [2];
  int          m_nreg [2] = '{32, 24};

  function automatic void model_edge(int d, bit r, bit w, int a, logic [63:0] wd);
    if (r) begin
      m_busy[d]    = 1'b1;
      m_cleared[d] = 0;
    end else if (m_busy[d]) begin
      m_cleared[d]++;
      m_mem[d][m_cleared[d]] = '0;
      if (m_cleared[d] == m_nreg[d] - 1) m_busy[d] = 1'b0;
    end else if (w && a != 0 && a < m_nreg[d]) begin
      m_mem[d][a] = wd;
    end
  endfunction

  function automatic logic [63:0] exp_rd(int d, int addr, bit w, int a, logic [63:0] wd);
    if (m_busy[d] || addr == 0 || addr >= m_nreg[d]) return 64'h0;
`ifdef RF_RISCV_MP_BYPASS_EN
    if (w && a == addr) return wd;
`endif
    return m_mem[d][addr];
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge(0, rst, we_a, int'(a3_a), wd_a);
    model_edge(1, rst, we_b, int'(a3_b), {32'h0, wd_b});
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] e;
    int n, nb;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    ra_a = 20'($urandom);
    ra_b = 10'($urandom);
    #1;
    n_checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_busy: got a=%b b=%b want 1 1", busy_a, busy_b);
    end
    for (int p = 0; p < 4; p++) begin
      e = exp_rd(0, int'(ra_a[p*5 +: 5]), we_a, int'(a3_a), wd_a);
      n_checks++;
      if (rd_a[p*64 +: 64] !== e) begin
        n_fail++;
        $display("FAIL reset_rd_a port%0d: got %h want %h", p, rd_a[p*64 +: 64], e);
      end
    end
    n = 0;
    nb = 0;
    while (busy_a === 1'b1 && n < 100) begin
      cycle();
      n++;
      if (busy_b !== 1'b1 && nb == 0) nb = n;
    end
    n_checks++;
    if (n != 31) begin
      n_fail++;
      $display("FAIL clear_len_a: got %0d cycles want 31", n);
    end
    n_checks++;
    if (nb != 23) begin
      n_fail++;
      $display("FAIL clear_len_b: got %0d cycles want 23", nb);
    end
  endtask

  task automatic test_clear_sequence();
    logic [63:0] e;
    int n;
    we_a = 1'b1; a3_a = 5'd5; wd_a = 64'hDEADBEEF;
    cycle();
    we_a = 1'b0;
    ra_a = {4{5'd5}};
    #1;
    n_checks++;
    if (rd_a[63:0] !== 64'hDEADBEEF) begin
      n_fail++;
      $display("FAIL preload_r5: got %h want %h", rd_a[63:0], 64'hDEADBEEF);
    end
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      cycle();
      n++;
    end
    n_checks++;
    if (n != 31) begin
      n_fail++;
      $display("FAIL clear_len_repulse: got %0d cycles want 31", n);
    end
    for (int p = 0; p < 4; p++) begin
      e = exp_rd(0, 5, 1'b0, 0, 64'h0);
      n_checks++;
      if (rd_a[p*64 +: 64] !== e || e !== 64'h0) begin
        n_fail++;
        $display("FAIL cleared_r5 port%0d: got %h want 0", p, rd_a[p*64 +: 64]);
      end
    end
  endtask

  task automatic test_basic_write();
    logic [63:0] e;
    we_a = 1'b1; a3_a = 5'd7; wd_a = 64'h12345678;
    cycle();
    we_a = 1'b0;
    ra_a = {5'd3, 5'd0, 5'd7, 5'd7};
    #1;
    for (int p = 0; p < 2; p++) begin
      n_checks++;
      if (rd_a[p*64 +: 64] !== 64'h12345678) begin
        n_fail++;
        $display("FAIL basic_r7 port%0d: got %h want %h", p, rd_a[p*64 +: 64], 64'h12345678);
      end
    end
    // Randomised traffic on both instances, reads biased towards the write address.
    for (int it = 0; it < 80; it++) begin
      we_a = 1'($urandom);
      a3_a = 5'($urandom);
      wd_a = {$urandom, $urandom};
      we_b = 1'($urandom);
      a3_b = 5'($urandom);
      wd_b = $urandom;
      for (int p = 0; p < 4; p++)
        ra_a[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? a3_a : 5'($urandom);
      for (int p = 0; p < 2; p++)
        ra_b[p*5 +: 5] = ($urandom_range(0, 3) == 0) ? a3_b : 5'($urandom);
      #1;
      for (int p = 0; p < 4; p++) begin
        e = exp_rd(0, int'(ra_a[p*5 +: 5]), we_a, int'(a3_a), wd_a);
        n_checks++;
        if (rd_a[p*64 +: 64] !== e) begin
          n_fail++;
          $display("FAIL rand_a it%0d port%0d ra=%0d: got %h want %h",
                   it, p, ra_a[p*5 +: 5], rd_a[p*64 +: 64], e);
        end
      end
      for (int p = 0; p < 2; p++) begin
        e = exp_rd(1, int'(ra_b[p*5 +: 5]), we_b, int'(a3_b), {32'h0, wd_b});
        n_checks++;
        if (rd_b[p*32 +: 32] !== e[31:0]) begin
          n_fail++;
          $display("FAIL rand_b it%0d port%0d ra=%0d: got %h want %h",
                   it, p, ra_b[p*5 +: 5], rd_b[p*32 +: 32], e[31:0]);
        end
      end
      n_checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_busy it%0d: got a=%b b=%b want 0 0", it, busy_a, busy_b);
      end
      cycle();
    end
    we_a = 1'b0;
    we_b = 1'b0;
  endtask

  task automatic test_x0_range();
    logic [63:0] e;
    we_a = 1'b1; a3_a = 5'd0; wd_a = '1;
    cycle();
    we_a = 1'b0;
    ra_a = '0;
    #1;
    n_checks++;
    if (rd_a !== '0) begin
      n_fail++;
      $display("FAIL x0_read: got %h want 0", rd_a);
    end
    we_b = 1'b1; a3_b = 5'd30; wd_b = 32'hFFFFFFFF;
    cycle();
    a3_b = 5'd23; wd_b = 32'hA5A5_0017;
    cycle();
    we_b = 1'b0;
    ra_b = {5'd23, 5'd30};
    #1;
    n_checks++;
    if (rd_b[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL range_r30: got %h want 0", rd_b[31:0]);
    end
    e = exp_rd(1, 23, 1'b0, 0, 64'h0);
    n_checks++;
    if (rd_b[63:32] !== e[31:0] || e[31:0] !== 32'hA5A5_0017) begin
      n_fail++;
      $display("FAIL range_r23: got %h want %h", rd_b[63:32], 32'hA5A5_0017);
    end
  endtask

  task automatic test_write_busy();
    int n;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      we_a = (n == 9);
      a3_a = 5'd3;
      wd_a = 64'hAA;
      cycle();
      n++;
    end
    we_a = 1'b0;
    ra_a = {4{5'd3}};
    #1;
    n_checks++;
    if (rd_a[63:0] !== 64'h0 || m_mem[0][3] !== 64'h0) begin
      n_fail++;
      $display("FAIL write_busy_r3: got %h want 0", rd_a[63:0]);
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 15; k++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    n = 0;
    while (busy_a === 1'b1 && n < 100) begin
      cycle();
      n++;
      if (n < 31 && busy_a !== 1'b1) begin
        n_checks++;
        n_fail++;
        $display("FAIL mid_clear_busy: got 0 at cycle %0d want 1", n);
      end
    end
    n_checks++;
    if (n != 31) begin
      n_fail++;
      $display("FAIL mid_clear_len: got %0d cycles want 31", n);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] e;
    we_a = 1'b1; a3_a = 5'd9; wd_a = 64'h1111;
    cycle();
    wd_a = 64'h55;
    ra_a = {5'd1, 5'd9, 5'd9, 5'd9};
    #1;
    e = exp_rd(0, 9, we_a, int'(a3_a), wd_a);
    n_checks++;
`ifdef RF_RISCV_MP_BYPASS_EN
    if (rd_a[63:0] !== e || e !== 64'h55) begin
`else
    if (rd_a[63:0] !== e || e !== 64'h1111) begin
`endif
      n_fail++;
      $display("FAIL bypass_same_cycle: got %h want %h", rd_a[63:0], e);
    end
    cycle();
    we_a = 1'b0;
    #1;
    n_checks++;
    if (rd_a[63:0] !== 64'h55) begin
      n_fail++;
      $display("FAIL bypass_after: got %h want %h", rd_a[63:0], 64'h55);
    end
  endtask

  initial begin
    rst  = 1'b1;
    we_a = 1'b0; a3_a = '0; wd_a = '0; ra_a = '0;
    we_b = 1'b0; a3_b = '0; wd_b = '0; ra_b = '0;
    test_reset();
    test_clear_sequence();
    test_basic_write();
    test_x0_range();
    test_write_busy();
    test_reset_mid_clear();
    test_bypass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_riscv_mp.md
# rf_riscv_mp

Parametrised multi-port integer register file for the RISC-V core, the next generation of the fixed 32×32, 2-read/1-write file. It generalises data width, register count and read-port count, and keeps x0 hard-wired to zero. It adds a sequential post-reset clear engine with a `busy` flag, and an optional write-to-read bypass. It sits between decode (read addresses) and writeback (write port).

## Interface
Parameters:
- `XLEN`, 32: data width in bits.
- `NREG`, 32: number of architectural registers, 2..32.
- `NRD`, 2: number of read ports, 1..4.
- `AW`, derived `$clog2(NREG)` with a minimum of 1: address width, not overridable.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `WE`, in, 1: write enable.
- `A3`, in, AW: write address.
- `WD3`, in, XLEN: write data.
- `RA`, in, NRD*AW: read addresses, packed; port i is `RA[i*AW +: AW]`.
- `RD`, out, NRD*XLEN: read data, packed the same way.
- `busy`, out, 1: high while the clear sequence runs; writes are ignored while high.

## Operation
- State machine with two states, CLEAR and READY, plus a clear counter `cnt` of width AW.
- Reset (`rst` high at an edge): state ← CLEAR, `cnt` ← 1. Reset wins over every other event, including mid-clear (the counter restarts at 1) and a simultaneous write (the write is dropped).
- CLEAR, `rst` low, each edge:
  - `mem[cnt]` ← 0.
  - If `cnt == NREG-1`, go to READY.
  - Otherwise `cnt` ← `cnt+1`.
  - `WE` is ignored.
- READY: if `WE`, `A3 != 0` and `A3 < NREG`, then `mem[A3]` ← `WD3` at the edge. All other writes are silently dropped.
- Reads are combinational (asynchronous): `RD[i] = mem[RA[i]]`.
  - Forced to 0 when `RA[i] == 0`.
  - Forced to 0 when `RA[i] >= NREG`.
  - Forced to 0 while `busy`.
- `busy` = (state == CLEAR). It is a registered state decode, so it has no combinational path from any input.
- x0 is never stored. Storage is `NREG-1` entries or an unused entry 0; the implementation chooses.

## Timing
- Reset values: state CLEAR, `cnt` = 1, `busy` = 1, all `RD` = 0.
- Clear latency: with `rst` sampled high at edge E0 and low from E1 on, registers 1..NREG-1 are cleared at E1..E(NREG-1). `busy` falls after E(NREG-1). For NREG=32 that is 31 cycles.
- Write latency: data written at edge E is visible on the reads after E.
- A same-cycle read of a register being written returns the old value, unless the bypass is compiled in.
- No handshake on the write port. The consumer must stall writeback while `busy` is high.

## Configuration
Macro: `RF_RISCV_MP_BYPASS_EN`.
- Defined: for each port i, if state is READY, `WE` is high, `A3 != 0`, `A3 < NREG` and `RA[i] == A3`, then `RD[i] = WD3` combinationally (write-first). The x0, out-of-range and `busy` zero-masking still take priority.
- Undefined: no bypass; a same-cycle read returns the stored value.

## Structure
- Shared package `rf_riscv_pkg` holds:
  - the state enum (`RF_CLEAR`, `RF_READY`);
  - `RF_XLEN_DEFAULT` = 32;
  - `RF_ZERO_ADDR` = 0.
- Sub-module `rf_riscv_rdport` implements one read port: address decode, zero/range/busy masking and the optional bypass mux. The top instantiates it NRD times in a generate loop.
- The top holds storage, the write logic, the FSM and the counter.

## Test plan
1. Clear sequence: preload reg 5 with 0xDEADBEEF, then pulse `rst` one cycle → `busy` high for exactly 31 cycles (NREG=32); afterwards reading reg 5 returns 0x0.
2. Basic write/read: `WE`=1, `A3`=7, `WD3`=0x12345678 → from the next cycle, `RA` port 0 = 7 gives 0x12345678; port 1 = 7 gives the same.
3. x0 and range: write 0xFFFFFFFF to `A3`=0 → reading address 0 gives 0. With NREG=24, a write to `A3`=30 is dropped and reading address 30 gives 0.
4. Write during busy: assert `WE` with `A3`=3 and `WD3`=0xAA during cycle 10 of the clear → after `busy` falls, reg 3 reads 0.
5. Reset mid-clear: reassert `rst` at clear cycle 15 → `busy` stays high and falls 31 cycles after the second reset's release.
6. Bypass: write 0x55 to reg 9 while `RA` port 0 = 9 in the same cycle → `RD` port 0 = 0x55 in that cycle with `RF_RISCV_MP_BYPASS_EN` defined, and the previous value without it. Run with NRD=4, XLEN=64.
